// File: rtl/map_sched_pkg.sv
// map_sched_pkg: shared widths, blanking length and FSM encodings for the map9v3 job scheduler
package map_sched_pkg;
  localparam int DP_W = 9;
  localparam int CNT_W = 8;
  localparam int N_W = 9;
  localparam int BLANK_CYC = 2;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t GRANT = 3'd1;
  localparam state_t LAUNCH = 3'd2;
  localparam state_t WAIT = 3'd3;
  localparam state_t RESP = 3'd4;
endpackage

// File: rtl/map_job_scheduler_if.sv
// map_job_scheduler_if: request fabric, response and engine bundle of the map9v3 job scheduler
interface map_job_scheduler_if import map_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_W*N_REQ-1:0] req_n;
  logic rsp_valid;
  logic rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [DP_W-1:0] rsp_dp;
  logic [CNT_W-1:0] rsp_counter;
  logic rsp_timeout;
  logic eng_start;
  logic [N_W-1:0] eng_n;
  logic eng_done;
  logic [DP_W-1:0] eng_dp;
  logic [CNT_W-1:0] eng_counter;
  logic busy;
  modport master (
    output req_valid, req_n, rsp_ready, eng_done, eng_dp, eng_counter,
    input req_ready, rsp_valid, rsp_id, rsp_dp, rsp_counter, rsp_timeout, eng_start, eng_n, busy
  );
  modport slave (
    input req_valid, req_n, rsp_ready, eng_done, eng_dp, eng_counter,
    output req_ready, rsp_valid, rsp_id, rsp_dp, rsp_counter, rsp_timeout, eng_start, eng_n, busy
  );
endinterface

// File: rtl/map_rr_arbiter.sv
// map_rr_arbiter: combinational round-robin pick, one-hot grant plus encoded id
module map_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  id
);
  int k;
  // scan from farthest to nearest so the requester closest to ptr is written last and wins
  always_comb begin
    gnt = '0;
    id = '0;
    k = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N_REQ;
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        id = ID_W'(k);
      end
    end
  end
endmodule

// File: rtl/map_job_scheduler.sv
// map_job_scheduler: shares one map9v3 engine between requesters, round-robin,
// with stale-done blanking and a watchdog that aborts hung jobs
module map_job_scheduler import map_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W = 10
) (
  input logic clock,
  input logic reset,
  map_job_scheduler_if.slave bus
);
  state_t state;
  logic [ID_W-1:0] ptr, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [TO_W-1:0] wd;
  logic done_q, done_edge, expired;
  map_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .id(gnt_id)
  );
  assign bus.req_ready = state == GRANT ? gnt : '0;
  assign bus.busy = state != IDLE;
  // wd counts WAIT cycles; the first BLANK_CYC of them ignore done left over from the last job
  assign done_edge = bus.eng_done & ~done_q & (wd >= TO_W'(BLANK_CYC));
  assign expired = wd == TO_W'(TIMEOUT - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      wd <= '0;
      done_q <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_n <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_dp <= '0;
      bus.rsp_counter <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      done_q <= bus.eng_done;
      case (state)
        IDLE: state <= |bus.req_valid ? GRANT : IDLE;
        GRANT: begin
          if (|gnt) begin
            bus.eng_n <= bus.req_n[int'(gnt_id)*N_W +: N_W];
            bus.rsp_id <= gnt_id;
            bus.eng_start <= 1'b1;
            ptr <= gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
            state <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          bus.eng_start <= 1'b0;
          wd <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (wd != TO_W'(TIMEOUT)) wd <= wd + 1'b1;
          if (done_edge) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_dp <= bus.eng_dp;
            bus.rsp_counter <= bus.eng_counter;
            bus.rsp_timeout <= 1'b0;
            state <= RESP;
          end else if (expired) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_dp <= '0;
            bus.rsp_counter <= '0;
            bus.rsp_timeout <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
